// File: rtl/usb_multi_ep_protocol_ctrl.sv
// -----------------------------------------------------------------------------
// usb_multi_ep_protocol_ctrl
//
// Bulk-transfer protocol controller for NUM_EP endpoints. Sits between the
// RX/TX packet engines and the shared data buffer and tracks, per endpoint,
// the DATA0/DATA1 toggles and the STALL condition. It also filters duplicate
// OUT data and retries IN data a bounded number of times when the host does
// not hand-shake in time. All outputs are a Moore decode of the registered
// state, so they change one cycle after the token/handshake that caused them.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   RX_Packet            received packet type pulse (IDLE/IN/OUT/ACK/ERROR/DONE/NAK)
//   RX_Endpoint          token endpoint, valid with IN/OUT
//   RX_Data_PID          toggle of the received DATA packet, valid with DONE
//   Buffer_Occupancy     bytes currently held in the shared buffer
//   TX_Packet_Data_Size  bytes the host side is loading for the next IN
//   Buffer_Reserved      host side is loading IN data
//   Reserved_Endpoint    endpoint that owns the data being loaded
//   Stall_Set/Clear      per-endpoint stall set / clear pulses
//   RX_Error             OUT packet rejected with NAK
//   RX_Transfer_Active   OUT data phase in progress
//   RX_Data_Ready        accepted OUT payload waiting in the buffer
//   TX_Transfer_Active   IN data phase in progress
//   TX_Error             IN packet dropped after the last retry (pulse)
//   D_Mode               1 = host->endpoint direction
//   TX_Packet            handshake/data request to the TX engine
//   TX_Data_PID          toggle to use with SEND_DATA
//   Active_Endpoint      endpoint of the current transaction
//   clear                flush the shared buffer
// -----------------------------------------------------------------------------
module usb_multi_ep_protocol_ctrl #(
  parameter  int NUM_EP      = 2,
  parameter  int BUF_DEPTH   = 64,
  parameter  int TIMEOUT_CYC = 800,
  parameter  int MAX_RETRY   = 3,
  localparam int EPW         = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int OCC_W       = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        RX_Packet,
  input  logic [EPW-1:0]    RX_Endpoint,
  input  logic              RX_Data_PID,
  input  logic [OCC_W-1:0]  Buffer_Occupancy,
  input  logic [OCC_W-1:0]  TX_Packet_Data_Size,
  input  logic              Buffer_Reserved,
  input  logic [EPW-1:0]    Reserved_Endpoint,
  input  logic [NUM_EP-1:0] Stall_Set,
  input  logic [NUM_EP-1:0] Stall_Clear,
  output logic              RX_Error,
  output logic              RX_Transfer_Active,
  output logic              RX_Data_Ready,
  output logic              TX_Transfer_Active,
  output logic              TX_Error,
  output logic              D_Mode,
  output logic [2:0]        TX_Packet,
  output logic              TX_Data_PID,
  output logic [EPW-1:0]    Active_Endpoint,
  output logic              clear
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(BUF_DEPTH);

  // Received packet codes (values 7 and out-of-context types are ignored).
  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_IN  = 3'd1, RX_OUT = 3'd2, RX_ACK = 3'd3,
    RX_ERR  = 3'd4, RX_DONE = 3'd5, RX_NAK = 3'd6
  } rx_pkt_e;

  // Requests to the TX engine.
  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_DATA  = 3'd1;
  localparam logic [2:0] TX_NAK   = 3'd2;
  localparam logic [2:0] TX_ACK   = 3'd3;
  localparam logic [2:0] TX_STALL = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RESERVED, ST_IN_WAIT, ST_IN_MODE, ST_IN_NAK, ST_IN_FAIL,
    ST_OUT_MODE, ST_OUT_WAIT, ST_OUT_ACK, ST_OUT_DUP, ST_OUT_NAK, ST_STALL
  } state_e;

  state_e            r_state;
  state_e            r_ret;          // state to resume after a one-cycle IN NAK
  logic [EPW-1:0]    r_ep;
  logic [NUM_EP-1:0] r_tx_tog;
  logic [NUM_EP-1:0] r_rx_tog;
  logic [NUM_EP-1:0] r_stall;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [RTY_W-1:0]  r_retry_cnt;
  logic              r_ack_first;    // first cycle of OUT_ACK entered from OUT_MODE
  logic              r_in_ack_clr;   // buffer flush in the cycle after an IN ACK

  state_e            w_state_nxt;
  logic              w_is_in;
  logic              w_is_out;
  logic              w_tok_bad;
  logic              w_ep_ld;
  logic [EPW-1:0]    w_ep_val;
  logic              w_tmo_clr;
  logic [RTY_W-1:0]  w_retry_nxt;
  logic              w_tx_flip;
  logic              w_rx_flip;
  logic              w_in_ack;

  assign w_is_in  = (RX_Packet == RX_IN);
  assign w_is_out = (RX_Packet == RX_OUT);
  // A token addressing a nonexistent endpoint is answered with STALL as well.
  assign w_tok_bad = (int'(RX_Endpoint) >= NUM_EP) || r_stall[RX_Endpoint];

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ep_ld     = 1'b0;
    w_ep_val    = RX_Endpoint;
    w_tmo_clr   = 1'b0;
    w_retry_nxt = r_retry_cnt;
    w_tx_flip   = 1'b0;
    w_rx_flip   = 1'b0;
    w_in_ack    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if ((w_is_in || w_is_out) && w_tok_bad) begin
          w_state_nxt = ST_STALL;
          w_ep_ld     = 1'b1;
        end else if (w_is_in) begin
          // No data has been reserved yet: the host has to come back later.
          w_state_nxt = ST_IN_NAK;
          w_ep_ld     = 1'b1;
        end else if (Buffer_Reserved) begin
          w_state_nxt = ST_RESERVED;
          w_ep_ld     = 1'b1;
          w_ep_val    = Reserved_Endpoint;
        end else if (w_is_out) begin
          // Stale bytes in the buffer mean there is nowhere to put the data.
          w_state_nxt = (Buffer_Occupancy != '0) ? ST_OUT_WAIT : ST_OUT_MODE;
          w_ep_ld     = 1'b1;
        end
      end

      ST_RESERVED: begin
        if (w_is_in)                                    w_state_nxt = ST_IN_NAK;
        else if (Buffer_Occupancy == TX_Packet_Data_Size) w_state_nxt = ST_IN_WAIT;
      end

      ST_IN_WAIT: begin
        if (w_is_in) begin
          if (RX_Endpoint == r_ep) begin
            w_state_nxt = ST_IN_MODE;
            w_tmo_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_IN_NAK;
          end
        end
      end

      ST_IN_MODE: begin
        if (RX_Packet == RX_ACK) begin
          w_state_nxt = ST_IDLE;
          w_tx_flip   = 1'b1;
          w_retry_nxt = '0;
          w_in_ack    = 1'b1;
        end else if ((RX_Packet == RX_NAK) || (r_tmo_cnt == TMO_LAST)) begin
          w_retry_nxt = r_retry_cnt + 1'b1;
          w_state_nxt = (w_retry_nxt == RTY_LIMIT) ? ST_IN_FAIL : ST_IN_WAIT;
        end
      end

      ST_IN_FAIL: begin
        w_state_nxt = ST_IDLE;
        w_retry_nxt = '0;
      end

      ST_IN_NAK: w_state_nxt = r_ret;

      ST_OUT_MODE: begin
        if ((RX_Packet == RX_ERR) || (Buffer_Occupancy > OCC_MAX)) begin
          w_state_nxt = ST_OUT_WAIT;
        end else if (RX_Packet == RX_DONE) begin
          // A toggle mismatch is a retransmission of data already accepted:
          // ACK it again but throw the copy away.
          if (RX_Data_PID == r_rx_tog[r_ep]) begin
            w_state_nxt = ST_OUT_ACK;
            w_rx_flip   = 1'b1;
          end else begin
            w_state_nxt = ST_OUT_DUP;
          end
        end
      end

      ST_OUT_WAIT: if (RX_Packet == RX_DONE) w_state_nxt = ST_OUT_NAK;

      ST_OUT_ACK: begin
        // Tokens arriving while the payload is still unread are refused
        // rather than silently dropped.
        if (w_is_in)                       w_state_nxt = ST_IN_NAK;
        else if (w_is_out)                 w_state_nxt = ST_OUT_NAK;
        else if (Buffer_Occupancy == '0)   w_state_nxt = ST_IDLE;
      end

      ST_OUT_DUP, ST_OUT_NAK, ST_STALL: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, endpoint context and per-endpoint registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-endpoint toggle and stall registers are reset along with
      // the FSM; a stale toggle after reset would make the first OUT look
      // like a duplicate.
      r_state      <= ST_IDLE;
      r_ret        <= ST_IDLE;
      r_ep         <= '0;
      r_tx_tog     <= '0;
      r_rx_tog     <= '0;
      r_stall      <= '0;
      r_tmo_cnt    <= '0;
      r_retry_cnt  <= '0;
      r_ack_first  <= 1'b0;
      r_in_ack_clr <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_retry_cnt  <= w_retry_nxt;
      r_ack_first  <= (r_state == ST_OUT_MODE) && (w_state_nxt == ST_OUT_ACK);
      r_in_ack_clr <= w_in_ack;

      if (w_state_nxt == ST_IN_NAK) r_ret <= r_state;
      if (w_ep_ld)                  r_ep  <= w_ep_val;

      // Saturates at the last count so a long stay cannot wrap back to 0.
      if (w_tmo_clr)
        r_tmo_cnt <= '0;
      else if ((r_state == ST_IN_MODE) && (r_tmo_cnt != TMO_LAST))
        r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (w_tx_flip) r_tx_tog[r_ep] <= ~r_tx_tog[r_ep];
      if (w_rx_flip) r_rx_tog[r_ep] <= ~r_rx_tog[r_ep];

      // Set dominates Clear. Clearing a stall restarts the endpoint from
      // DATA0 in both directions, overriding any flip on the same edge.
      for (int i = 0; i < NUM_EP; i++) begin
        if (Stall_Set[i]) begin
          r_stall[i] <= 1'b1;
        end else if (Stall_Clear[i]) begin
          r_stall[i]  <= 1'b0;
          r_tx_tog[i] <= 1'b0;
          r_rx_tog[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    RX_Error           = 1'b0;
    RX_Transfer_Active = 1'b0;
    RX_Data_Ready      = 1'b0;
    TX_Transfer_Active = 1'b0;
    TX_Error           = 1'b0;
    D_Mode             = 1'b0;
    TX_Packet          = TX_IDLE;
    TX_Data_PID        = 1'b0;
    Active_Endpoint    = r_ep;
    clear              = r_in_ack_clr;

    case (r_state)
      ST_IN_MODE: begin
        TX_Transfer_Active = 1'b1;
        TX_Packet          = TX_DATA;
        TX_Data_PID        = r_tx_tog[r_ep];
      end
      ST_IN_FAIL: begin
        TX_Error = 1'b1;
        clear    = 1'b1;
      end
      ST_IN_NAK: TX_Packet = TX_NAK;
      ST_OUT_MODE: begin
        D_Mode             = 1'b1;
        RX_Transfer_Active = 1'b1;
      end
      ST_OUT_WAIT: begin
        D_Mode             = 1'b1;
        RX_Transfer_Active = 1'b1;
        clear              = 1'b1;
      end
      ST_OUT_ACK: begin
        RX_Data_Ready = 1'b1;
        if (r_ack_first) TX_Packet = TX_ACK;
      end
      ST_OUT_DUP: begin
        TX_Packet = TX_ACK;
        clear     = 1'b1;
      end
      ST_OUT_NAK: begin
        TX_Packet = TX_NAK;
        RX_Error  = 1'b1;
        clear     = 1'b1;
      end
      ST_STALL: TX_Packet = TX_STALL;
      default: ;
    endcase
  end

endmodule
